fetch_sequencer: RTL and testbench

Parametrised fetch stage that owns the program counter and the single synchronous RAM read port. It sequences instruction fetches, including an optional extension (immediate) word, and serves datapath load requests between instructions. It routes each returned RAM word to either the instruction register or the memory-data register, and holds both until they are overwritten. It sits between the unified program/data RAM and the decoder/control FSM.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_sequencer.sv | 148 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and state encoding for the fetch sequencer
package fetch_pkg;

    localparam int         DEF_DATA_WIDTH = 16;
    localparam int         DEF_ADDR_WIDTH = 16;
    localparam int         DEF_OPCODE_WIDTH = 4;
    localparam logic [3:0] DEF_EXT_OPCODE = 4'hF;

    typedef enum logic [2:0] {
        FETCH    = 3'd0,
        IWAIT    = 3'd1,
        EXTWAIT  = 3'd2,
        DISPATCH = 3'd3,
        DWAIT    = 3'd4,
        DDONE    = 3'd5
    } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner and RAM read-port sequencer for instruction/extension fetch and loads
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                      DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int                      ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC     = '0,
    parameter int                      OPCODE_WIDTH = DEF_OPCODE_WIDTH,
    parameter logic [OPCODE_WIDTH-1:0] EXT_OPCODE   = OPCODE_WIDTH'(DEF_EXT_OPCODE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] imm,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_target,
    input  logic                  data_req,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_data_valid,
    output logic                  fetch_phase,
    output logic [ADDR_WIDTH-1:0] pc
);

    fetch_state_t          r_state;
    fetch_state_t          w_next_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_instr;
    logic [DATA_WIDTH-1:0] r_imm;
    logic [DATA_WIDTH-1:0] r_mem_data;

    logic                  w_rd_en;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_instr_valid;
    logic                  w_data_valid;
    logic                  w_fetch_phase;
    logic                  w_is_ext;
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_pc_inc;

    assign w_pc_inc = r_pc + ADDR_WIDTH'(1);
    assign w_is_ext = (mem_rdata[DATA_WIDTH-1 -: OPCODE_WIDTH] == EXT_OPCODE);
    assign w_accept = (r_state == DISPATCH) && !data_req && instr_ready;

    always_comb begin
        w_next_state  = r_state;
        w_rd_en       = 1'b0;
        w_addr        = r_pc;
        w_instr_valid = 1'b0;
        w_data_valid  = 1'b0;
        w_fetch_phase = 1'b0;
        case (r_state)
            FETCH: begin
                w_rd_en       = 1'b1;
                w_fetch_phase = 1'b1;
                w_next_state  = IWAIT;
            end
            IWAIT: begin
                w_fetch_phase = 1'b1;
                if (w_is_ext) begin
                    w_rd_en      = 1'b1;
                    w_addr       = w_pc_inc;
                    w_next_state = EXTWAIT;
                end else begin
                    w_next_state = DISPATCH;
                end
            end
            EXTWAIT: begin
                w_fetch_phase = 1'b1;
                w_next_state  = DISPATCH;
            end
            DISPATCH: begin
                w_instr_valid = 1'b1;
                // A pending load wins over the decoder's accept in the same cycle.
                if (data_req) begin
                    w_rd_en      = 1'b1;
                    w_addr       = data_addr;
                    w_next_state = DWAIT;
                end else if (instr_ready) begin
                    w_next_state = FETCH;
                end
            end
            DWAIT: begin
                w_next_state = DDONE;
            end
            DDONE: begin
                w_instr_valid = 1'b1;
                w_data_valid  = 1'b1;
                w_next_state  = DISPATCH;
            end
            default: begin
                w_next_state = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FETCH;
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_imm      <= '0;
            r_mem_data <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IWAIT: begin
                    r_instr <= mem_rdata;
                    r_pc    <= w_pc_inc;
                    if (!w_is_ext) begin
                        r_imm <= '0;
                    end
                end
                EXTWAIT: begin
                    r_imm <= mem_rdata;
                    r_pc  <= w_pc_inc;
                end
                DISPATCH: begin
                    if (w_accept && pc_load) begin
                        r_pc <= pc_target;
                    end
                end
                DWAIT: begin
                    r_mem_data <= mem_rdata;
                end
                default: begin
                end
            endcase
        end
    end

    // Reset leaves the state in FETCH, so the FETCH-phase strobes are masked while reset is held.
    assign mem_rd_en      = w_rd_en & rst_n;
    assign fetch_phase    = w_fetch_phase & rst_n;
    assign mem_addr       = w_addr;
    assign instr_valid    = w_instr_valid;
    assign mem_data_valid = w_data_valid;
    assign instr          = r_instr;
    assign imm            = r_imm;
    assign mem_data       = r_mem_data;
    assign pc             = r_pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer against a transaction-level model
module tb_fetch_sequencer;

    localparam logic [15:0] RST_PC = 16'h0010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata = '0;
    logic [15:0] instr;
    logic [15:0] imm;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        pc_load = 1'b0;
    logic [15:0] pc_target = '0;
    logic        data_req = 1'b0;
    logic [15:0] data_addr = '0;
    logic [15:0] mem_data;
    logic        mem_data_valid;
    logic        fetch_phase;
    logic [15:0] pc;

    fetch_sequencer #(
        .DATA_WIDTH  (16),
        .ADDR_WIDTH  (16),
        .RESET_PC    (RST_PC),
        .OPCODE_WIDTH(4),
        .EXT_OPCODE  (4'hF)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_rd_en     (mem_rd_en),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .instr         (instr),
        .imm           (imm),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .pc_load       (pc_load),
        .pc_target     (pc_target),
        .data_req      (data_req),
        .data_addr     (data_addr),
        .mem_data      (mem_data),
        .mem_data_valid(mem_data_valid),
        .fetch_phase   (fetch_phase),
        .pc            (pc)
    );

    always #5 clk = ~clk;

    logic [15:0] ram [0:65535];

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= ram[mem_addr];
    end

    logic [15:0] m_pc;
    logic [15:0] m_instr;
    logic [15:0] m_imm;
    logic [15:0] m_mem_data;
    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_pc       = RST_PC;
        m_instr    = '0;
        m_imm      = '0;
        m_mem_data = '0;
    endtask

    task automatic check_reset_outputs();
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_instr", instr, 0);
        check("rst_imm", imm, 0);
        check("rst_mem_data", mem_data, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_mdv", mem_data_valid, 0);
        check("rst_fetch_phase", fetch_phase, 0);
        check("rst_pc", pc, RST_PC);
    endtask

    // Called with the DUT in FETCH; returns at the first cycle with instr_valid.
    task automatic fetch_check();
        logic [15:0] w;
        logic [15:0] ext_addr;
        bit          ext;
        int          lat;
        check("fetch_rd_en", mem_rd_en, 1);
        check("fetch_addr", mem_addr, m_pc);
        check("fetch_phase", fetch_phase, 1);
        w        = ram[m_pc];
        ext      = (w[15:12] == 4'hF);
        ext_addr = m_pc + 16'd1;
        lat      = 0;
        do begin
            step();
            lat++;
            if (lat == 1) begin
                check("iwait_rd_en", mem_rd_en, ext ? 1 : 0);
                if (ext) check("ext_addr", mem_addr, ext_addr);
            end
        end while (!instr_valid && lat < 6);
        check("fetch_latency", lat, ext ? 3 : 2);
        m_instr = w;
        m_imm   = ext ? ram[ext_addr] : 16'h0000;
        m_pc    = m_pc + (ext ? 16'd2 : 16'd1);
        check("instr", instr, m_instr);
        check("imm", imm, m_imm);
        check("pc", pc, m_pc);
        check("mem_data_sticky", mem_data, m_mem_data);
        check("dispatch_phase", fetch_phase, 0);
    endtask

    task automatic do_load(input logic [15:0] addr, input logic rdy);
        data_req    = 1'b1;
        data_addr   = addr;
        instr_ready = rdy;
        pc_load     = 1'($urandom);
        pc_target   = 16'($urandom);
        #1;
        check("load_rd_en", mem_rd_en, 1);
        check("load_addr", mem_addr, addr);
        step();
        data_req    = 1'($urandom);
        instr_ready = 1'($urandom);
        check("dwait_mdv", mem_data_valid, 0);
        check("dwait_ivalid", instr_valid, 0);
        step();
        data_req    = 1'($urandom);
        instr_ready = 1'($urandom);
        m_mem_data  = ram[addr];
        check("ddone_mdv", mem_data_valid, 1);
        check("ddone_mem_data", mem_data, m_mem_data);
        check("ddone_instr", instr, m_instr);
        check("ddone_ivalid", instr_valid, 1);
        step();
        data_req    = 1'b0;
        instr_ready = 1'b0;
        check("post_load_mdv", mem_data_valid, 0);
        check("post_load_ivalid", instr_valid, 1);
        check("post_load_pc", pc, m_pc);
    endtask

    task automatic stall_with_pc_load();
        data_req    = 1'b0;
        instr_ready = 1'b0;
        pc_load     = 1'b1;
        pc_target   = 16'($urandom);
        step();
        pc_load = 1'b0;
        check("stall_ivalid", instr_valid, 1);
        check("stall_pc", pc, m_pc);
        check("stall_phase", fetch_phase, 0);
    endtask

    task automatic accept(input logic load, input logic [15:0] target);
        data_req    = 1'b0;
        instr_ready = 1'b1;
        pc_load     = load;
        pc_target   = target;
        step();
        instr_ready = 1'b0;
        pc_load     = 1'($urandom);
        pc_target   = 16'($urandom);
        if (load) m_pc = target;
        #1;
        fetch_check();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 16'($urandom);
        ram[16'h0010] = 16'h1234;
        ram[16'h0011] = 16'h2222;
        ram[16'h0200] = 16'hCAFE;
        ram[16'h0040] = 16'h3333;
        ram[16'hFFFF] = 16'hF123;
        ram[16'h0000] = 16'h5555;
        ram[16'h0300] = 16'hF00A;

        model_reset();
        step();
        step();
        check_reset_outputs();
        rst_n = 1'b1;
        #1;

        fetch_check();
        accept(1'b0, 16'h0000);
        do_load(16'h0200, 1'b1);
        check("load_mem_data", mem_data, 16'hCAFE);
        stall_with_pc_load();
        accept(1'b1, 16'h0040);
        check("sticky_after_fetch", mem_data, 16'hCAFE);
        accept(1'b1, 16'hFFFF);
        check("wrap_pc", pc, 16'h0001);

        data_req    = 1'b0;
        instr_ready = 1'b1;
        pc_load     = 1'b1;
        pc_target   = 16'h0300;
        step();
        instr_ready = 1'b0;
        pc_load     = 1'b0;
        step();
        step();
        check("extwait_phase", fetch_phase, 1);
        check("extwait_rd_en", mem_rd_en, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        ram[16'h0010] = 16'hF005;
        ram[16'h0011] = 16'hBEEF;
        model_reset();
        step();
        step();
        check_reset_outputs();
        rst_n = 1'b1;
        #1;
        fetch_check();
        check("ext_instr", instr, 16'hF005);
        check("ext_imm", imm, 16'hBEEF);

        for (int n = 0; n < 150; n++) begin
            int loads;
            loads = $urandom_range(0, 2);
            for (int k = 0; k < loads; k++) do_load(16'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) stall_with_pc_load();
            accept($urandom_range(0, 3) == 0, 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
